// File: rtl/alu_sweep_ctrl.sv
// Sweep initiator for the combinational ALU: latches one operand pair, steps the
// opcode 0..7 with a programmable settle time, and captures res/ov per opcode.
`timescale 1ns/1ps

module alu_sweep_ctrl #(
  parameter int DWIDTH      = 32,
  parameter int RWIDTH      = 64,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DWIDTH-1:0] op_a,
  input  logic [DWIDTH-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DWIDTH-1:0] alu_a,
  output logic [DWIDTH-1:0] alu_b,
  output logic [2:0]        alu_opcode,
  input  logic [RWIDTH-1:0] alu_res,
  input  logic              alu_ov,
  input  logic [2:0]        rd_idx,
  output logic [RWIDTH-1:0] rd_res,
  output logic              rd_ov,
  output logic [7:0]        ov_mask,
  output logic [1:0]        dbg_state
);

  if (RWIDTH != 2 * DWIDTH) begin : g_bad_rwidth
    $error("alu_sweep_ctrl: RWIDTH must equal 2*DWIDTH");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("alu_sweep_ctrl: HOLD_CYCLES must be within 1..15");
  end

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [3:0]        hold_cnt;
  logic [RWIDTH-1:0] res_buf [8];
  logic [7:0]        ov_buf;
  logic              accept;

  // start only matters in IDLE; DRIVE/CAPTURE/FINISH never look at it.
  assign accept    = (state == IDLE) && start;
  assign busy      = (state == DRIVE) || (state == CAPTURE);
  assign done      = (state == FINISH);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (hold_cnt == HOLD_LAST) state_nxt = CAPTURE;
      CAPTURE: state_nxt = (alu_opcode == 3'd7) ? FINISH : DRIVE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands, opcode, hold counter and the result buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      hold_cnt   <= '0;
      ov_mask    <= '0;
      ov_buf     <= '0;
      for (int i = 0; i < 8; i++) begin
        res_buf[i] <= '0;
      end
    end else begin
      if (accept) begin
        alu_a      <= op_a;
        alu_b      <= op_b;
        alu_opcode <= 3'd0;
        hold_cnt   <= 4'd0;
        ov_mask    <= 8'd0;
      end else if (state == DRIVE) begin
        hold_cnt <= hold_cnt + 4'd1;
      end else if (state == CAPTURE) begin
        res_buf[alu_opcode] <= alu_res;
        ov_buf[alu_opcode]  <= alu_ov;
        ov_mask[alu_opcode] <= alu_ov;
        // Opcode 7 is terminal; it stays put so the ALU inputs remain stable.
        if (alu_opcode != 3'd7) begin
          alu_opcode <= alu_opcode + 3'd1;
          hold_cnt   <= 4'd0;
        end
      end
    end
  end

  // Read port sees the registered contents, so a same-cycle write shows up next cycle.
  assign rd_res = res_buf[rd_idx];
  assign rd_ov  = ov_buf[rd_idx];

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Bench for alu_sweep_ctrl: two instances (settle 2 and settle 1) driven by an
// ALU stand-in, checked against a cycle-count timing model and a result scoreboard.
`timescale 1ns/1ps

module tb_alu_sweep_ctrl;

  localparam int DW = 32;
  localparam int RW = 64;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic          start_v   [2];
  logic [DW-1:0] op_a, op_b;
  logic [2:0]    rd_idx;
  logic          busy_v    [2];
  logic          done_v    [2];
  logic [DW-1:0] alu_a_v   [2];
  logic [DW-1:0] alu_b_v   [2];
  logic [2:0]    opc_v     [2];
  logic [RW:0]   alu_out_v [2];
  logic [RW-1:0] rd_res_v  [2];
  logic          rd_ov_v   [2];
  logic [7:0]    ov_mask_v [2];
  logic [1:0]    dbg_v     [2];

  int checks = 0;
  int errors = 0;
  bit alu_mode = 1'b0;

  // scoreboard: {ov, res} per opcode, pushed at launch, popped after done
  logic [RW:0]   exp_q[$];
  logic [RW:0]   model_buf [2][8];
  logic [DW-1:0] lat_a [2];
  logic [DW-1:0] lat_b [2];

  // mode 0: simple stub; mode 1: arithmetic/logic ALU stand-in
  function automatic logic [RW:0] alu_fn(input bit mode, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b, input logic [2:0] op);
    logic [RW-1:0] r;
    logic          ov;
    r  = '0;
    ov = 1'b0;
    if (!mode) begin
      r  = {29'h0, op, b};
      ov = op[0];
    end else begin
      case (op)
        3'd0: begin r = 64'(a) + 64'(b); ov = r[32]; end
        3'd1: begin r = 64'(a) - 64'(b); ov = (a < b); end
        3'd2: begin r = 64'(a) * 64'(b); ov = |r[63:32]; end
        3'd3: begin r = {32'h0, a & b}; ov = 1'b0; end
        3'd4: begin r = {32'h0, a | b}; ov = 1'b0; end
        3'd5: begin r = {32'h0, a ^ b}; ov = ^a; end
        3'd6: begin r = {32'h0, a} << b[4:0]; ov = |r[63:32]; end
        default: begin r = {32'h0, a} >> b[4:0]; ov = a[0]; end
      endcase
    end
    return {ov, r};
  endfunction

  assign alu_out_v[0] = alu_fn(alu_mode, alu_a_v[0], alu_b_v[0], opc_v[0]);
  assign alu_out_v[1] = alu_fn(alu_mode, alu_a_v[1], alu_b_v[1], opc_v[1]);

  alu_sweep_ctrl #(.DWIDTH(DW), .RWIDTH(RW), .HOLD_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op_a(op_a), .op_b(op_b),
    .busy(busy_v[0]), .done(done_v[0]), .alu_a(alu_a_v[0]), .alu_b(alu_b_v[0]),
    .alu_opcode(opc_v[0]), .alu_res(alu_out_v[0][RW-1:0]), .alu_ov(alu_out_v[0][RW]),
    .rd_idx(rd_idx), .rd_res(rd_res_v[0]), .rd_ov(rd_ov_v[0]),
    .ov_mask(ov_mask_v[0]), .dbg_state(dbg_v[0])
  );

  alu_sweep_ctrl #(.DWIDTH(DW), .RWIDTH(RW), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op_a(op_a), .op_b(op_b),
    .busy(busy_v[1]), .done(done_v[1]), .alu_a(alu_a_v[1]), .alu_b(alu_b_v[1]),
    .alu_opcode(opc_v[1]), .alu_res(alu_out_v[1][RW-1:0]), .alu_ov(alu_out_v[1][RW]),
    .rd_idx(rd_idx), .rd_res(rd_res_v[1]), .rd_ov(rd_ov_v[1]),
    .ov_mask(ov_mask_v[1]), .dbg_state(dbg_v[1])
  );

  task automatic check(input string tag, input logic [RW:0] obs, input logic [RW:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input int s);
    check("rst_busy", 65'(busy_v[s]), 65'(0));
    check("rst_done", 65'(done_v[s]), 65'(0));
    check("rst_alu_a", 65'(alu_a_v[s]), 65'(0));
    check("rst_alu_b", 65'(alu_b_v[s]), 65'(0));
    check("rst_opcode", 65'(opc_v[s]), 65'(0));
    check("rst_ov_mask", 65'(ov_mask_v[s]), 65'(0));
    for (int k = 0; k < 8; k++) begin
      rd_idx = 3'(k);
      #1;
      check("rst_buf", {rd_ov_v[s], rd_res_v[s]}, 65'(0));
      model_buf[s][k] = '0;
    end
  endtask

  // driver: present operands with start for one edge, then scramble the inputs
  task automatic launch(input int s, input logic [DW-1:0] a, input logic [DW-1:0] b);
    op_a       = a;
    op_b       = b;
    start_v[s] = 1'b1;
    lat_a[s]   = a;
    lat_b[s]   = b;
    for (int k = 0; k < 8; k++) exp_q.push_back(alu_fn(alu_mode, a, b, 3'(k)));
    tick();
    start_v[s] = 1'b0;
    op_a       = $urandom;
    op_b       = $urandom;
  endtask

  // follows one sweep from cycle 1 to the idle cycle after done
  task automatic watch(input int s, input bit inject);
    int          h;
    int          n;
    int          k;
    logic [RW:0] e;
    logic [7:0]  exp_mask;
    h = (s == 0) ? 2 : 1;
    n = 8 * (h + 1);
    for (int c = 1; c <= n + 1; c++) begin
      check("busy", 65'(busy_v[s]), 65'(c <= n));
      check("done", 65'(done_v[s]), 65'(c == n + 1));
      if (c == 1) check("mask_clr", 65'(ov_mask_v[s]), 65'(0));
      if (c <= n) begin
        k = (c - 1) / (h + 1);
        check("opcode", 65'(opc_v[s]), 65'(k));
        check("alu_a", 65'(alu_a_v[s]), 65'(lat_a[s]));
        check("alu_b", 65'(alu_b_v[s]), 65'(lat_b[s]));
        if (c % (h + 1) == 0) begin
          rd_idx = 3'(k);
          #1;
          check("rd_old", {rd_ov_v[s], rd_res_v[s]}, model_buf[s][k]);
        end
      end
      if (inject && c == 5) begin
        start_v[s] = 1'b1;
        op_a       = 32'h1;
      end
      if (c <= n) tick();
      if (inject && c == 5) start_v[s] = 1'b0;
    end
    exp_mask = '0;
    for (int j = 0; j < 8; j++) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 65'(exp_q.size()), 65'(8 - j));
        break;
      end
      e = exp_q.pop_front();
      exp_mask[j] = e[RW];
      rd_idx = 3'(j);
      #1;
      check("rd_new", {rd_ov_v[s], rd_res_v[s]}, e);
      model_buf[s][j] = e;
    end
    check("ov_mask", 65'(ov_mask_v[s]), 65'(exp_mask));
    tick();
    check("idle_done", 65'(done_v[s]), 65'(0));
    check("idle_busy", 65'(busy_v[s]), 65'(0));
  endtask

  initial begin
    int dones;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    op_a   = '0;
    op_b   = '0;
    rd_idx = '0;

    repeat (3) @(posedge clk);
    #1;
    check_cleared(0);
    check_cleared(1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // basic sweep with stub ALU
    launch(0, 32'hA5A5A5A5, 32'h5A5A5A5A);
    watch(0, 1'b0);
    check("ov_mask_aa", 65'(ov_mask_v[0]), 65'(8'hAA));
    rd_idx = 3'd5;
    #1;
    check("rd5_res", 65'(rd_res_v[0]), 65'(64'h00000005_5A5A5A5A));
    check("rd5_ov", 65'(rd_ov_v[0]), 65'(1));
    tick();

    // start pulse mid-sweep is ignored
    launch(0, 32'hA5A5A5A5, 32'h5A5A5A5A);
    watch(0, 1'b1);

    // back-to-back: start in the idle cycle right after done
    launch(0, $urandom, 32'hFFFFFFFF);
    watch(0, 1'b0);
    launch(0, $urandom, $urandom);
    watch(0, 1'b0);

    // settle of one cycle
    launch(1, $urandom, $urandom);
    watch(1, 1'b0);

    // ALU stand-in with random operands on both instances
    alu_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      launch(0, $urandom, $urandom);
      watch(0, 1'b0);
      launch(1, $urandom, $urandom);
      watch(1, 1'b0);
    end

    // asynchronous reset during DRIVE of opcode 3
    launch(0, $urandom, $urandom);
    repeat (9) tick();
    check("pre_rst_opcode", 65'(opc_v[0]), 65'(3));
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_cleared(0);
    check_cleared(1);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done_v[0] || busy_v[0]) dones++;
    end
    check("no_done_after_rst", 65'(dones), 65'(0));
    check("opcode_after_rst", 65'(opc_v[0]), 65'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_sweep_ctrl.md
Name: alu_sweep_ctrl

Overview:
Synthesizable initiator for the combinational ALU (a, b, opcode -> res, ov).
- On a start request it latches one operand pair and drives it to the ALU.
- It steps the opcode through 0..7, holding each opcode for a programmable settle time.
- It captures res/ov per opcode into an 8-entry result buffer, which is then readable by index.
- It replaces the hand-sequenced stimulus flow with hardware, and sits between a host/control port and the ALU instance.

Parameters:
- DWIDTH, 32, operand width (ALU a/b).
- RWIDTH, 64, result width; must equal 2*DWIDTH.
- HOLD_CYCLES, 2, settle cycles per opcode before capture. Legal range 1..15; 0 is illegal.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  sweep request; sampled only in IDLE.
- op_a  input  DWIDTH  operand A, latched on accepted start.
- op_b  input  DWIDTH  operand B, latched on accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  single-cycle pulse when all 8 results are captured.
- alu_a  output  DWIDTH  to ALU a.
- alu_b  output  DWIDTH  to ALU b.
- alu_opcode  output  3  to ALU opcode.
- alu_res  input  RWIDTH  from ALU res.
- alu_ov  input  1  from ALU ov.
- rd_idx  input  3  result buffer read index.
- rd_res  output  RWIDTH  buffer[rd_idx].res; combinational read.
- rd_ov  output  1  buffer[rd_idx].ov; combinational read.
- ov_mask  output  8  bit k = captured ov for opcode k.

Behaviour:
Reset (async, rst_n low):
- State goes to IDLE.
- busy=0, done=0, alu_a=0, alu_b=0, alu_opcode=0, ov_mask=0.
- All buffer entries cleared to res=0, ov=0.
- Reset asserted mid-sweep aborts the sweep immediately; no partial done.

FSM states: IDLE, DRIVE, CAPTURE, FINISH.
- IDLE:
  - start=1 at a rising edge: latch op_a/op_b into alu_a/alu_b, set alu_opcode=0, set hold counter=0, clear ov_mask to 0, go to DRIVE.
  - start=0: alu_* hold their last values.
- DRIVE:
  - Increment the hold counter each cycle.
  - After HOLD_CYCLES cycles in DRIVE, go to CAPTURE.
  - alu_a/alu_b/alu_opcode are stable throughout.
- CAPTURE (exactly 1 cycle):
  - At the closing edge, write alu_res/alu_ov into buffer[alu_opcode] and set ov_mask[alu_opcode]=alu_ov.
  - If alu_opcode==7, go to FINISH.
  - Otherwise increment alu_opcode, reset the hold counter, and go to DRIVE.
- FINISH (exactly 1 cycle): done=1, busy=0, then go to IDLE.

Timing (edge 0 = edge that accepts start):
- busy=1 for cycles 1..8*(HOLD_CYCLES+1).
- done=1 in cycle 8*(HOLD_CYCLES+1)+1 only.
- With HOLD_CYCLES=2, done is high in cycle 25.

Boundary and corner rules:
- start while busy or in FINISH: ignored, with no effect on operands or sequence.
- start in the cycle immediately after the done pulse (back in IDLE): accepted; starts a new sweep.
- op_a/op_b changes during a sweep: no effect; only the latched values are driven.
- Buffer reads are allowed at any time. During a sweep, entries not yet captured return values from the previous sweep (ov_mask is already cleared).
- Opcode never wraps inside a sweep; 7 is terminal.
- Buffer write to an index and a read of the same index in the same cycle: the read returns the old value; the new value is visible next cycle.

Test Plan:
- Basic sweep, HOLD_CYCLES=2:
  - Stimulus: op_a=32'hA5A5A5A5, op_b=32'h5A5A5A5A, start pulse; ALU stub res={29'h0,alu_opcode,alu_b}, ov=alu_opcode[0].
  - Required: alu_opcode steps 0..7, each held 3 cycles; done pulses once at cycle 25; ov_mask=8'hAA; rd_idx=5 gives rd_res=64'h00000005_5A5A5A5A, rd_ov=1.
- Real ALU hookup, same operands:
  - Stimulus: connect the actual alu instance and run a sweep.
  - Required: for every k, buffer[k] matches the ALU output observed with opcode=k applied combinationally.
- Ignored start:
  - Stimulus: pulse start with op_a=32'h1 at cycle 5 of a running sweep.
  - Required: alu_a stays A5A5A5A5; done still at cycle 25; exactly one done pulse.
- Reset mid-sweep:
  - Stimulus: drop rst_n during DRIVE of opcode 3.
  - Required: busy=0, alu_opcode=0, ov_mask=0 and all buffer entries 0 immediately (asynchronously); no done pulse.
- Back-to-back sweeps:
  - Stimulus: start asserted in the cycle after done, with op_b=32'hFFFFFFFF.
  - Required: second sweep accepted; alu_b=FFFFFFFF; second done 25 cycles after its start edge.
- HOLD_CYCLES=1:
  - Stimulus: run a sweep.
  - Required: each opcode held 2 cycles; done at cycle 17.
